// File: rtl/bus_ram_target_if.sv
// Shared initiator/target bus used by bus_ram_target.
// Targets drive outputs to 0 when idle so several can be wire-ORed.
interface bus_ram_target_if;
    logic        beginTransactionIn;
    logic        readNotWriteIn;
    logic        endTransactionIn;
    logic        dataValidIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic [31:0] addressDataIn;
    logic        endTransactionOut;
    logic        dataValidOut;
    logic        busErrorOut;
    logic        busyOut;
    logic [31:0] addressDataOut;

    modport slave (
        input  beginTransactionIn, readNotWriteIn, endTransactionIn,
        input  dataValidIn, byteEnablesIn, burstSizeIn, addressDataIn,
        output endTransactionOut, dataValidOut, busErrorOut, busyOut,
        output addressDataOut
    );

    modport master (
        output beginTransactionIn, readNotWriteIn, endTransactionIn,
        output dataValidIn, byteEnablesIn, burstSizeIn, addressDataIn,
        input  endTransactionOut, dataValidOut, busErrorOut, busyOut,
        input  addressDataOut
    );
endinterface

// File: rtl/bus_ram_target.sv
// Burst-capable RAM target on a multiplexed address/data bus.
// All outputs are registered and held at 0 when not signalling.
module bus_ram_target #(
    parameter logic [31:0] baseAddress = 32'h50000000,
    parameter int          nrOfWords   = 1024
) (
    input  logic             clock,
    input  logic             reset,
    bus_ram_target_if.slave  bus
);
    localparam int          AW   = (nrOfWords > 1) ? $clog2(nrOfWords) : 1;
    localparam logic [32:0] SPAN = 33'(nrOfWords) << 2;

    typedef enum logic [2:0] {
        IDLE, DECODE, READ, READ_END, WRITE, ERR_READ, ERR_WAIT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic          r_done, w_done_nxt;
    logic [3:0]    r_be, w_be_nxt;
    logic          r_rnw, w_rnw_nxt;
    logic          r_end, w_end_nxt;
    logic          r_dv, w_dv_nxt;
    logic          r_err, w_err_nxt;
    logic          r_busy, w_busy_nxt;
    logic [31:0]   r_data, w_data_nxt;
    logic          w_we;

    logic [31:0]   r_ram [nrOfWords];

    logic [31:0]   w_off;
    logic          w_claim;
    logic [AW-1:0] w_start;
    logic          w_overrun;
    logic          w_unused;

    assign w_off     = bus.addressDataIn - baseAddress;
    assign w_claim   = (bus.addressDataIn >= baseAddress) &&
                       ({1'b0, w_off} < SPAN);
    assign w_start   = w_off[AW+1:2];
    assign w_overrun = (32'(r_idx) + 32'(r_cnt)) >= 32'(nrOfWords);
    assign w_unused  = ^{w_off[31:AW+2], w_off[1:0]};

    assign bus.endTransactionOut = r_end;
    assign bus.dataValidOut      = r_dv;
    assign bus.busErrorOut       = r_err;
    assign bus.busyOut           = r_busy;
    assign bus.addressDataOut    = r_data;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_be_nxt    = r_be;
        w_rnw_nxt   = r_rnw;
        w_end_nxt   = 1'b0;
        w_dv_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_data_nxt  = '0;
        w_we        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.beginTransactionIn && w_claim) begin
                    w_state_nxt = DECODE;
                    w_idx_nxt   = w_start;
                    w_cnt_nxt   = bus.burstSizeIn;
                    w_be_nxt    = bus.byteEnablesIn;
                    w_rnw_nxt   = bus.readNotWriteIn;
                    w_done_nxt  = 1'b0;
                    w_busy_nxt  = !bus.readNotWriteIn;
                end
            end
            DECODE: begin
                if (w_overrun) begin
                    w_state_nxt = r_rnw ? ERR_READ : ERR_WAIT;
                    w_err_nxt   = 1'b1;
                end else if (r_rnw) begin
                    w_state_nxt = READ;
                    w_dv_nxt    = 1'b1;
                    w_data_nxt  = r_ram[r_idx];
                    w_idx_nxt   = r_idx + AW'(1);
                end else begin
                    w_state_nxt = WRITE;
                end
            end
            // r_cnt counts words still to send after the one on the bus
            READ: begin
                if (bus.endTransactionIn) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = READ_END;
                    w_end_nxt   = 1'b1;
                end else begin
                    w_dv_nxt   = 1'b1;
                    w_data_nxt = r_ram[r_idx];
                    w_idx_nxt  = r_idx + AW'(1);
                    w_cnt_nxt  = r_cnt - 8'd1;
                end
            end
            READ_END: begin
                w_state_nxt = IDLE;
            end
            WRITE: begin
                if (bus.dataValidIn && !r_done) begin
                    w_we      = 1'b1;
                    w_idx_nxt = r_idx + AW'(1);
                    if (r_cnt == 8'd0) w_done_nxt = 1'b1;
                    else               w_cnt_nxt  = r_cnt - 8'd1;
                end
                if (bus.endTransactionIn) w_state_nxt = IDLE;
            end
            ERR_READ: begin
                w_state_nxt = READ_END;
                w_end_nxt   = 1'b1;
            end
            ERR_WAIT: begin
                if (bus.endTransactionIn) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_be    <= '0;
            r_rnw   <= 1'b0;
            r_end   <= 1'b0;
            r_dv    <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_be    <= w_be_nxt;
            r_rnw   <= w_rnw_nxt;
            r_end   <= w_end_nxt;
            r_dv    <= w_dv_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // RAM has no reset so contents survive an aborted burst
    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_ram[r_idx][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_ram_target.sv
// Scoreboard bench for bus_ram_target: model RAM plus expected-read queue.
// Each task drives one scenario and checks the outputs cycle by cycle.
module tb_bus_ram_target;
    localparam logic [31:0] BASE = 32'h50000000;
    localparam int          NW   = 1024;

    logic clock;
    logic reset;
    bus_ram_target_if bus ();

    bus_ram_target #(
        .baseAddress (BASE),
        .nrOfWords   (NW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [NW];
    logic [31:0] exp_q [$];
    logic [31:0] wq [$];
    logic [35:0] w_outs;

    assign w_outs = {bus.endTransactionOut, bus.dataValidOut,
                     bus.busErrorOut, bus.busyOut, bus.addressDataOut};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus.beginTransactionIn = 1'b0;
        bus.readNotWriteIn     = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.dataValidIn        = 1'b0;
        bus.byteEnablesIn      = 4'h0;
        bus.burstSizeIn        = 8'h0;
        bus.addressDataIn      = 32'h0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int burst,
                               input logic [3:0] be, input int nwords,
                               input bit exp_err);
        int          idx;
        logic [31:0] d;
        idx = int'((addr - BASE) >> 2);
        bus.beginTransactionIn = 1'b1;
        bus.readNotWriteIn     = 1'b0;
        bus.addressDataIn      = addr;
        bus.burstSizeIn        = 8'(burst);
        bus.byteEnablesIn      = be;
        tick();
        idle_bus();
        n_cmp++;
        if (w_outs !== {3'b000, 1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL wr_cycle1 got=%h want=%h", w_outs,
                     {3'b000, 1'b1, 32'h0});
        end
        tick();
        n_cmp++;
        if (w_outs !== {2'b00, exp_err, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL wr_cycle2 got=%h want=%h", w_outs,
                     {2'b00, exp_err, 1'b0, 32'h0});
        end
        for (int i = 0; i < nwords; i++) begin
            d = wq.pop_front();
            bus.dataValidIn      = 1'b1;
            bus.addressDataIn    = d;
            bus.endTransactionIn = (i == nwords - 1);
            if (!exp_err && i <= burst) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[idx+i][8*b +: 8] = d[8*b +: 8];
                end
            end
            tick();
        end
        idle_bus();
        tick();
        n_cmp++;
        if (w_outs !== 36'h0) begin
            n_bad++;
            $display("FAIL wr_tail got=%h want=0", w_outs);
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input int burst,
                              input int poke);
        int          idx;
        logic [31:0] w;
        idx = int'((addr - BASE) >> 2);
        for (int i = 0; i <= burst; i++) exp_q.push_back(model[idx+i]);
        bus.beginTransactionIn = 1'b1;
        bus.readNotWriteIn     = 1'b1;
        bus.addressDataIn      = addr;
        bus.burstSizeIn        = 8'(burst);
        bus.byteEnablesIn      = 4'hF;
        tick();
        idle_bus();
        n_cmp++;
        if (w_outs !== 36'h0) begin
            n_bad++;
            $display("FAIL rd_cycle1 got=%h want=0", w_outs);
        end
        for (int c = 2; c <= burst + 3; c++) begin
            if (c == poke) begin
                bus.beginTransactionIn = 1'b1;
                bus.readNotWriteIn     = 1'b0;
                bus.addressDataIn      = BASE;
            end else begin
                idle_bus();
            end
            tick();
            if (c <= burst + 2) begin
                if (bus.dataValidOut === 1'b1) w = exp_q.pop_front();
                else w = 32'hxxxxxxxx;
                n_cmp++;
                if (bus.dataValidOut !== 1'b1 || bus.addressDataOut !== w ||
                    bus.endTransactionOut !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rd_data cyc=%0d got dv=%b d=%h end=%b want dv=1 d=%h end=0",
                             c, bus.dataValidOut, bus.addressDataOut,
                             bus.endTransactionOut, w);
                end
            end else begin
                n_cmp++;
                if (w_outs !== {1'b1, 35'h0}) begin
                    n_bad++;
                    $display("FAIL rd_end cyc=%0d got=%h want=%h", c, w_outs,
                             {1'b1, 35'h0});
                end
            end
        end
        idle_bus();
        tick();
        n_cmp++;
        if (w_outs !== 36'h0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rd_tail got=%h left=%0d want=0/0", w_outs,
                     exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_bus();
        repeat (3) tick();
        n_cmp++;
        if (w_outs !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_outs got=%h want=0", w_outs);
        end
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
        write_burst(BASE + 8, 3, 4'hF, 4, 1'b0);
        read_burst(BASE + 8, 3, -1);
    endtask

    task automatic test_byte_enables();
        wq.push_back(32'h0);
        write_burst(BASE, 0, 4'hF, 1, 1'b0);
        wq.push_back(32'hFFFFFFFF);
        write_burst(BASE, 0, 4'b0101, 1, 1'b0);
        n_cmp++;
        if (model[0] !== 32'h00FF00FF) begin
            n_bad++;
            $display("FAIL be_model got=%h want=00ff00ff", model[0]);
        end
        read_burst(BASE, 0, -1);
    endtask

    task automatic test_unclaimed();
        logic [31:0] addrs [2];
        addrs[0] = BASE - 4;
        addrs[1] = BASE + 32'(4 * NW);
        for (int a = 0; a < 2; a++) begin
            bus.beginTransactionIn = 1'b1;
            bus.readNotWriteIn     = a[0];
            bus.addressDataIn      = addrs[a];
            bus.byteEnablesIn      = 4'hF;
            tick();
            for (int c = 1; c <= 4; c++) begin
                idle_bus();
                bus.dataValidIn   = 1'b1;
                bus.addressDataIn = 32'hDEADBEEF;
                tick();
                n_cmp++;
                if (w_outs !== 36'h0) begin
                    n_bad++;
                    $display("FAIL unclaimed a=%h cyc=%0d got=%h want=0",
                             addrs[a], c, w_outs);
                end
            end
            idle_bus();
            tick();
        end
        read_burst(BASE, 0, -1);
    endtask

    task automatic test_overrun();
        logic [35:0] want [4];
        want[0] = 36'h0;
        want[1] = {2'b00, 1'b1, 33'h0};
        want[2] = {1'b1, 35'h0};
        want[3] = 36'h0;
        bus.beginTransactionIn = 1'b1;
        bus.readNotWriteIn     = 1'b1;
        bus.addressDataIn      = BASE + 32'(4 * (NW - 2));
        bus.burstSizeIn        = 8'd3;
        tick();
        idle_bus();
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (w_outs !== want[c-1]) begin
                n_bad++;
                $display("FAIL ovr_read cyc=%0d got=%h want=%h", c, w_outs,
                         want[c-1]);
            end
            tick();
        end
        wq.push_back(32'hA5A5A5A5);
        write_burst(BASE + 32'(4 * (NW - 1)), 0, 4'hF, 1, 1'b0);
        wq.push_back(32'h11111111);
        wq.push_back(32'h22222222);
        write_burst(BASE + 32'(4 * (NW - 1)), 1, 4'hF, 2, 1'b1);
        read_burst(BASE + 32'(4 * (NW - 1)), 0, -1);
    endtask

    task automatic test_extra_words();
        for (int i = 0; i < 3; i++) wq.push_back(32'hCCCC0000 + 32'(i));
        write_burst(BASE + 32'(4 * 300), 2, 4'hF, 3, 1'b0);
        for (int i = 1; i <= 4; i++) wq.push_back(32'(i * 32'h11));
        write_burst(BASE + 32'(4 * 300), 1, 4'hF, 4, 1'b0);
        read_burst(BASE + 32'(4 * 300), 2, -1);
    endtask

    task automatic test_begin_ignored();
        read_burst(BASE + 8, 3, 4);
        read_burst(BASE, 0, -1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 16; i++) wq.push_back($urandom);
        write_burst(BASE + 32'(4 * 400), 15, 4'hF, 16, 1'b0);
        bus.beginTransactionIn = 1'b1;
        bus.readNotWriteIn     = 1'b1;
        bus.addressDataIn      = BASE + 32'(4 * 400);
        bus.burstSizeIn        = 8'd15;
        tick();
        idle_bus();
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_cmp++;
            if (bus.dataValidOut !== 1'b1 ||
                bus.addressDataOut !== model[400 + c - 2]) begin
                n_bad++;
                $display("FAIL abort_data cyc=%0d got dv=%b d=%h want dv=1 d=%h",
                         c, bus.dataValidOut, bus.addressDataOut,
                         model[400 + c - 2]);
            end
        end
        bus.endTransactionIn = 1'b1;
        tick();
        bus.endTransactionIn = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            n_cmp++;
            if (w_outs !== 36'h0) begin
                n_bad++;
                $display("FAIL abort_quiet cyc=%0d got=%h want=0", c, w_outs);
            end
            if (c < 7) tick();
        end
        read_burst(BASE + 32'(4 * 400), 1, -1);
    endtask

    task automatic test_reset_mid();
        bus.beginTransactionIn = 1'b1;
        bus.readNotWriteIn     = 1'b1;
        bus.addressDataIn      = BASE + 32'(4 * 400);
        bus.burstSizeIn        = 8'd15;
        tick();
        idle_bus();
        repeat (3) tick();
        n_cmp++;
        if (bus.dataValidOut !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_active got dv=%b want 1", bus.dataValidOut);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (w_outs !== 36'h0) begin
            n_bad++;
            $display("FAIL rst_mid_outs got=%h want=0", w_outs);
        end
        #1;
        reset = 1'b1;
        read_burst(BASE + 8, 3, -1);
    endtask

    task automatic test_long_burst();
        for (int i = 0; i < 256; i++) begin
            wq.push_back((32'(i) * 32'h01010101) ^ 32'h5A000000);
        end
        write_burst(BASE + 64, 255, 4'hF, 256, 1'b0);
        read_burst(BASE + 64, 255, -1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_unclaimed();
        test_overrun();
        test_extra_words();
        test_begin_ignored();
        test_abort();
        test_reset_mid();
        test_long_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
